tt_sweep_ctrl: RTL
==================

# tt_sweep_ctrl

Sequencer that exhaustively drives every input combination of a small combinational unit (the 3-input p1/p2/p3 -> res function block). It captures the response to each vector into a truth-table register and compares the result against an expected table. It sits between a control/status interface and the unit under test, replacing free-running stimulus with a clocked, repeatable scan. One run is triggered by a start pulse and finishes with a one-cycle done pulse plus pass/fail status.

## Interface
- N_IN, 3, number of unit inputs; table width is 2**N_IN
- SETTLE, 2, cycles each vector is held before sampling; legal range 1..15
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  begin a scan; sampled only in IDLE
- exp_table  input  2**N_IN  expected response; bit k is expected res for vector k; sampled live during the scan
- dut_res  input  1  unit output (res)
- dut_in  output  N_IN  vector driven to unit; dut_in[2]=p1, dut_in[1]=p2, dut_in[0]=p3 (MSB is slowest-changing)
- busy  output  1  high from the cycle after start is accepted through the DONE cycle
- done  output  1  one-cycle pulse; final result valid
- table_out  output  2**N_IN  captured truth table; bit k = res for vector k
- match  output  1  table_out == exp_table at completion
- fail_idx  output  N_IN  lowest vector index that mismatched; 0 if none

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- Reset: IDLE, dut_in=0, busy=0, done=0, table_out=0, match=0, fail_idx=0, idx=0, settle counter=0, fail_seen=0.
- IDLE & start=1: next state SETTLE, idx=0, dut_in=0, cnt=SETTLE-1, table_out=0, match=0, fail_idx=0, fail_seen=0.
- SETTLE: dut_in=idx is held; cnt decrements each cycle. If cnt==0, go to SAMPLE.
- SAMPLE, one cycle: at the ending edge, table_out[idx]<=dut_res.
  - If dut_res!=exp_table[idx] and !fail_seen: fail_idx<=idx and fail_seen<=1.
  - If idx==2**N_IN-1, go to DONE.
  - Otherwise idx<=idx+1, dut_in<=idx+1, cnt<=SETTLE-1, and return to SETTLE.
- DONE, one cycle: done=1, busy=1, match=!fail_seen. Next state is IDLE.
- In IDLE, table_out/match/fail_idx hold their last values until the next accepted start.
- dut_in stays at the last vector (all ones) after a scan until the next start or reset.
- start while busy is ignored, including in the DONE cycle. start in IDLE on the cycle after DONE is accepted.
- idx is N_IN bits. The terminal test uses idx==all-ones, so there is no wrap.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Per vector: SETTLE cycles in SETTLE plus 1 cycle in SAMPLE, so the vector is stable for SETTLE+1 edges before capture.
- Start accepted at edge E0: busy=1 and dut_in=0 from E0. done=1 for the cycle after edge E0 + 2**N_IN*(SETTLE+1). With defaults that is 24 edges, and done is low again after edge 25.
- Total busy duration: 2**N_IN*(SETTLE+1)+1 cycles.
- rst mid-scan: the next cycle is IDLE with all reset values. Partial table is discarded and no done pulse is produced.
- rst and start together: rst wins.

## Test plan
- Reset check: hold rst 3 cycles, pulse start with rst=1 -> all outputs 0, busy stays 0.
- Model unit res=(p1&p2)|p3 with exp_table=8'hEA, SETTLE=2 -> dut_in steps 0..7, each held 3 cycles; done 24 edges after start; table_out=8'hEA, match=1, fail_idx=0.
- Same model, exp_table=8'hE2 -> table_out=8'hEA, match=0, fail_idx=3.
- Model res=1 with exp_table=8'h7F -> match=0, fail_idx=7; a second back-to-back start accepted the cycle after done reproduces an identical result.
- Assert rst at cycle 10 of a scan -> busy=0 and table_out=0 the next cycle; no done pulse; a fresh start completes normally.
- start pulsed every cycle during a scan -> only one done pulse; the scan length is unchanged.

Source files
------------

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: exhaustive vector sweep of a small combinational unit.
// Each vector is driven, held for SETTLE cycles, then sampled once into
// a truth-table register. The first mismatching index is recorded, and the
// end of the scan is marked by a one-cycle done pulse with match status.
module tt_sweep_ctrl #(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   exp_table,
    input  logic                 dut_res,
    output logic [N_IN-1:0]      dut_in,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 match,
    output logic [N_IN-1:0]      fail_idx
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t          state;
    logic [N_IN-1:0] idx;
    logic [CW-1:0]   cnt;
    logic            fail_seen;
    logic            mismatch_c;
    logic            last_c;

    // Response disagrees with expectation for the vector currently sampled
    assign mismatch_c = (dut_res != exp_table[idx]);
    assign last_c     = (idx == {N_IN{1'b1}});

    // Sweep sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            cnt       <= '0;
            fail_seen <= 1'b0;
            dut_in    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= '0;
            match     <= 1'b0;
            fail_idx  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_SETTLE;
                        idx       <= '0;
                        dut_in    <= '0;
                        cnt       <= CW'(SETTLE - 1);
                        table_out <= '0;
                        match     <= 1'b0;
                        fail_idx  <= '0;
                        fail_seen <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        state <= S_SAMPLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_SAMPLE: begin
                    table_out[idx] <= dut_res;
                    if (mismatch_c && !fail_seen) begin
                        fail_idx  <= idx;
                        fail_seen <= 1'b1;
                    end
                    if (last_c) begin
                        // match reflects any mismatch seen, including this last vector
                        state <= S_DONE;
                        done  <= 1'b1;
                        match <= !(fail_seen || mismatch_c);
                    end else begin
                        state  <= S_SETTLE;
                        idx    <= idx + N_IN'(1);
                        dut_in <= idx + N_IN'(1);
                        cnt    <= CW'(SETTLE - 1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
